// File: rtl/mix_pkg.sv
// Shared definitions for the mixer-stack operand path: source modes, sequencer
// states and the element type.
package mix_pkg;

  localparam int unsigned ELEM_W = 16;
  typedef logic [ELEM_W-1:0] elem_t;

  localparam logic [1:0] MODE_EMB   = 2'd0;
  localparam logic [1:0] MODE_PASS  = 2'd1;
  localparam logic [1:0] MODE_BCAST = 2'd2;
  localparam logic [1:0] MODE_TRN   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mix_operand_mux.sv
// Combinational mode -> operand formatting: pad embedding, pass, row broadcast
// or transpose. Transpose network built only with MIX_SEQ_TRANSPOSE_EN defined.
module mix_operand_mux
  import mix_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned EMB_DIM = 16,
  parameter int unsigned HID_DIM = 16,
  parameter int unsigned N_LEN   = 16
) (
  input  logic [1:0]                       mode_i,
  input  logic [N*EMB_DIM*N_LEN-1:0]       emb_i,
  input  logic [HID_DIM*HID_DIM*N_LEN-1:0] mix_i,
  output logic [HID_DIM*HID_DIM*N_LEN-1:0] operand_c
);

  localparam int unsigned EW = N * EMB_DIM * N_LEN;

  always_comb begin
    operand_c = '0;
    case (mode_i)
      MODE_EMB: operand_c[EW-1:0] = emb_i;
      MODE_BCAST: begin
        for (int i = 0; i < HID_DIM; i++) begin
          for (int j = 0; j < HID_DIM; j++) begin
            operand_c[(HID_DIM*i+j)*N_LEN +: N_LEN] = mix_i[(HID_DIM*i)*N_LEN +: N_LEN];
          end
        end
      end
      MODE_TRN: begin
`ifdef MIX_SEQ_TRANSPOSE_EN
        for (int i = 0; i < HID_DIM; i++) begin
          for (int j = 0; j < HID_DIM; j++) begin
            operand_c[(HID_DIM*i+j)*N_LEN +: N_LEN] = mix_i[(HID_DIM*j+i)*N_LEN +: N_LEN];
          end
        end
`else
        operand_c = mix_i;
`endif
      end
      default: operand_c = mix_i;
    endcase
  end

endmodule

// File: rtl/mix_input_sequencer.sv
// Operand sequencer for the mixer stack: buffers embedding and mix results and
// issues one formatted operand per layer. Optional transpose: MIX_SEQ_TRANSPOSE_EN.
module mix_input_sequencer
  import mix_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned EMB_DIM  = 16,
  parameter int unsigned HID_DIM  = 16,
  parameter int unsigned N_LEN    = 16,
  parameter int unsigned N_LAYERS = 3,
  parameter int unsigned LW       = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [2*N_LAYERS-1:0]            layer_mode,
  input  logic [N*EMB_DIM*N_LEN-1:0]       d_emb,
  input  logic                             valid_emb,
  input  logic [HID_DIM*HID_DIM*N_LEN-1:0] d_mix,
  input  logic                             valid_mix,
  output logic [HID_DIM*HID_DIM*N_LEN-1:0] q,
  output logic                             q_valid,
  input  logic                             q_ready,
  output logic [LW-1:0]                    layer_idx,
  output logic                             busy,
  output logic                             done
);

  localparam int unsigned EW = N * EMB_DIM * N_LEN;
  localparam int unsigned QW = HID_DIM * HID_DIM * N_LEN;

  state_e                state_q, state_d;
  logic [LW-1:0]         layer_q, layer_d;
  logic [2*N_LAYERS-1:0] modes_q, modes_d;
  logic [EW-1:0]         emb_q, emb_d;
  logic [QW-1:0]         mix_q, mix_d;
  logic [QW-1:0]         q_q, q_d;
  logic                  q_valid_q, q_valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [1:0]            mode_sel_c;
  logic [QW-1:0]         operand_c;

  // Operand is formatted from next-state values so q is registered and ready
  // on the same cycle q_valid rises.
  assign mode_sel_c = 2'(modes_d >> {layer_d, 1'b0});

  mix_operand_mux #(
    .N       (N),
    .EMB_DIM (EMB_DIM),
    .HID_DIM (HID_DIM),
    .N_LEN   (N_LEN)
  ) u_mux (
    .mode_i    (mode_sel_c),
    .emb_i     (emb_d),
    .mix_i     (mix_d),
    .operand_c (operand_c)
  );

  // Next state, layer counter, mode latch and buffer capture
  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    modes_d = modes_q;
    emb_d   = emb_q;
    mix_d   = mix_q;
    case (state_q)
      ST_IDLE: begin
        if (valid_emb) emb_d = d_emb;
        if (start) begin
          state_d = ST_ISSUE;
          layer_d = '0;
          modes_d = layer_mode;
        end
      end
      ST_ISSUE: begin
        if (q_valid_q && q_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (valid_mix) begin
          mix_d = d_mix;
          if (layer_q == LW'(N_LAYERS - 1)) begin
            state_d = ST_DONE;
          end else begin
            layer_d = layer_q + LW'(1);
            state_d = ST_ISSUE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs derived from the next state
  always_comb begin
    q_valid_d = (state_d == ST_ISSUE);
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
    q_d       = q_valid_d ? operand_c : mix_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      layer_q   <= '0;
      modes_q   <= '0;
      emb_q     <= '0;
      mix_q     <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      layer_q   <= layer_d;
      modes_q   <= modes_d;
      emb_q     <= emb_d;
      mix_q     <= mix_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign q         = q_q;
  assign q_valid   = q_valid_q;
  assign layer_idx = layer_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mix_input_sequencer.sv
// Self-checking bench for mix_input_sequencer: table of runs with a reference
// operand model and scoreboard queue, plus a hand-written mid-run reset.
module tb_mix_input_sequencer;
  import mix_pkg::*;

  localparam int unsigned N    = 4;
  localparam int unsigned EMB  = 16;
  localparam int unsigned HID  = 16;
  localparam int unsigned NL   = 16;
  localparam int unsigned NLAY = 3;
  localparam int unsigned LW   = 2;
  localparam int unsigned EW   = N * EMB * NL;
  localparam int unsigned QW   = HID * HID * NL;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic [2*NLAY-1:0]    layer_mode;
  logic [EW-1:0]        d_emb;
  logic                 valid_emb;
  logic [QW-1:0]        d_mix;
  logic                 valid_mix;
  logic [QW-1:0]        q;
  logic                 q_valid;
  logic                 q_ready;
  logic [LW-1:0]        layer_idx;
  logic                 busy;
  logic                 done;

  mix_input_sequencer #(
    .N(N), .EMB_DIM(EMB), .HID_DIM(HID), .N_LEN(NL), .N_LAYERS(NLAY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .layer_mode(layer_mode),
    .d_emb(d_emb), .valid_emb(valid_emb), .d_mix(d_mix), .valid_mix(valid_mix),
    .q(q), .q_valid(q_valid), .q_ready(q_ready), .layer_idx(layer_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*NLAY-1:0] modes;
    int                stall;
    bit                emb_new;
    bit                pat;
    bit                spur;
  } vec_t;

  int            errors = 0;
  int            checks = 0;
  logic [QW-1:0] sb[$];
  logic [EW-1:0] emb_m;
  logic [QW-1:0] mix_m;
  logic [2*NLAY-1:0] modes_m;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_q(input string name, input logic [QW-1:0] act, input logic [QW-1:0] exp);
    bit shown;
    checks++;
    if (act !== exp) begin
      errors++;
      shown = 1'b0;
      for (int e = 0; e < HID*HID; e++) begin
        if (!shown && act[e*NL +: NL] !== exp[e*NL +: NL]) begin
          $display("FAIL %s: element %0d got %0h expected %0h", name, e,
                   act[e*NL +: NL], exp[e*NL +: NL]);
          shown = 1'b1;
        end
      end
    end
  endtask

  function automatic elem_t el(input logic [QW-1:0] v, input int i, input int j);
    return v[(HID*i+j)*NL +: NL];
  endfunction

  // Reference operand for one mode, built element by element
  function automatic logic [QW-1:0] model_q(input logic [1:0] m, input logic [EW-1:0] e,
                                            input logic [QW-1:0] x);
    logic [QW-1:0] r;
    int dst;
    r = '0;
    for (int i = 0; i < HID; i++) begin
      for (int j = 0; j < HID; j++) begin
        dst = HID*i + j;
        case (m)
          2'd0: if (dst < N*EMB) r[dst*NL +: NL] = e[dst*NL +: NL];
          2'd1: r[dst*NL +: NL] = el(x, i, j);
          2'd2: r[dst*NL +: NL] = el(x, i, 0);
          default: begin
`ifdef MIX_SEQ_TRANSPOSE_EN
            r[dst*NL +: NL] = el(x, j, i);
`else
            r[dst*NL +: NL] = el(x, i, j);
`endif
          end
        endcase
      end
    end
    return r;
  endfunction

  function automatic logic [QW-1:0] incr(input logic [QW-1:0] x);
    logic [QW-1:0] r;
    for (int e = 0; e < HID*HID; e++) r[e*NL +: NL] = x[e*NL +: NL] + NL'(1);
    return r;
  endfunction

  function automatic logic [QW-1:0] pattern();
    logic [QW-1:0] r;
    for (int i = 0; i < HID; i++)
      for (int j = 0; j < HID; j++) r[(HID*i+j)*NL +: NL] = NL'(16*i + j);
    return r;
  endfunction

  function automatic logic [EW-1:0] emb_pat(input int base);
    logic [EW-1:0] r;
    for (int e = 0; e < N*EMB; e++) r[e*NL +: NL] = NL'(base + e);
    return r;
  endfunction

  // One complete run: scoreboard holds the operand expected for each layer
  task automatic do_run(input vec_t v);
    logic [QW-1:0] exp_q, res;
    int waited;
    if (v.spur) begin
      d_mix = ~mix_m; valid_mix = 1'b1;
      step();
      valid_mix = 1'b0;
    end
    if (v.emb_new) begin
      d_emb = emb_pat(16'h100); valid_emb = 1'b1; emb_m = d_emb;
    end
    layer_mode = v.modes; modes_m = v.modes; start = 1'b1;
    step();
    start = 1'b0; valid_emb = 1'b0; layer_mode = ~v.modes;
    for (int k = 0; k < NLAY; k++) begin
      sb.push_back(model_q(modes_m[2*k +: 2], emb_m, mix_m));
      waited = 0;
      while (!q_valid && waited < 20) begin step(); waited++; end
      chk("q_valid_latency", 32'(waited), 32'd0);
      chk("q_valid_issue", 32'(q_valid), 32'd1);
      chk("busy_issue", 32'(busy), 32'd1);
      chk("layer_idx", 32'(layer_idx), 32'(k));
      exp_q = sb.pop_front();
      chk_q("q_operand", q, exp_q);
      for (int s = 0; s < v.stall; s++) begin
        if (v.spur && s == 0) begin
          d_mix = ~exp_q; valid_mix = 1'b1; start = 1'b1;
        end
        step();
        valid_mix = 1'b0; start = 1'b0;
        chk("q_valid_stall", 32'(q_valid), 32'd1);
        chk_q("q_stable", q, exp_q);
      end
      q_ready = 1'b1;
      step();
      q_ready = 1'b0;
      chk("q_valid_drop", 32'(q_valid), 32'd0);
      res = v.pat ? pattern() : incr(exp_q);
      for (int c = 0; c < 3; c++) begin
        if (v.spur && c == 1) begin
          d_emb = {32{$urandom}}; valid_emb = 1'b1; start = 1'b1;
        end
        step();
        valid_emb = 1'b0; start = 1'b0;
        chk("q_valid_wait", 32'(q_valid), 32'd0);
      end
      d_mix = res; valid_mix = 1'b1; mix_m = res;
      step();
      valid_mix = 1'b0;
    end
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_in_done", 32'(busy), 32'd1);
    chk_q("q_final", q, mix_m);
    step();
    chk("done_low", 32'(done), 32'd0);
    chk("busy_low", 32'(busy), 32'd0);
    chk_q("q_after_done", q, mix_m);
    step();
    chk("no_extra_run", 32'(busy | q_valid | done), 32'd0);
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{modes: {MODE_BCAST, MODE_PASS, MODE_EMB},  stall: 0, emb_new: 0, pat: 0, spur: 0};
    vecs[1] = '{modes: {MODE_BCAST, MODE_PASS, MODE_EMB},  stall: 5, emb_new: 0, pat: 0, spur: 1};
    vecs[2] = '{modes: {MODE_TRN,   MODE_BCAST, MODE_PASS}, stall: 1, emb_new: 0, pat: 1, spur: 0};
    vecs[3] = '{modes: {MODE_PASS,  MODE_EMB,  MODE_TRN},  stall: 2, emb_new: 1, pat: 0, spur: 1};

    rst_n = 1'b0; start = 1'b0; layer_mode = '0; d_emb = '0; valid_emb = 1'b0;
    d_mix = '0; valid_mix = 1'b0; q_ready = 1'b0;
    emb_m = '0; mix_m = '0; modes_m = '0;
    step(); step();
    chk("rst_q_valid", 32'(q_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_layer_idx", 32'(layer_idx), 32'd0);
    chk_q("rst_q", q, '0);
    rst_n = 1'b1;
    step();

    d_emb = emb_pat(1); valid_emb = 1'b1; emb_m = d_emb;
    step();
    valid_emb = 1'b0;

    for (int n = 0; n < 4; n++) do_run(vecs[n]);

    // Reset asserted in WAIT of layer 1
    layer_mode = vecs[0].modes; start = 1'b1;
    step();
    start = 1'b0; q_ready = 1'b1;
    step();
    q_ready = 1'b0;
    step(); step();
    d_mix = pattern(); valid_mix = 1'b1;
    step();
    valid_mix = 1'b0; q_ready = 1'b1;
    step();
    q_ready = 1'b0;
    chk("mid_layer_idx", 32'(layer_idx), 32'd1);
    chk("mid_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_q_valid", 32'(q_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_layer_idx", 32'(layer_idx), 32'd0);
    chk_q("arst_q", q, '0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("arst_no_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    emb_m = '0; mix_m = '0;
    step();
    chk("post_rst_idle", 32'(busy | done), 32'd0);
    do_run(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mix_input_sequencer.md
# mix_input_sequencer

Parametrised operand sequencer for the mixer stack, between the embedding stage and the shared mix layer. It buffers the embedding vector and each mix-layer result. For each of `N_LAYERS` passes it presents a source-selected operand matrix on a valid/ready handshake, then pulses `done` after the last result returns. It replaces fixed three-state operand selection with a per-layer run-time mode table, layer counting, backpressure and an optional transpose mode.

## Interface
- `N`, 4: tokens per sequence.
- `EMB_DIM`, 16: embedding width per token.
- `HID_DIM`, 16: hidden matrix dimension, giving an operand of `HID_DIM*HID_DIM` elements. Constraint: `N*EMB_DIM <= HID_DIM*HID_DIM`.
- `N_LEN`, 16: element width in bits.
- `N_LAYERS`, 3: passes per run, must be ≥1.
- `LW`, `$clog2(N_LAYERS)` (min 1): layer index width.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: begin a run (honoured in IDLE only).
- `layer_mode` in `2*N_LAYERS`: per-layer source, 2 bits per layer; layer k uses bits `[2k+:2]`.
- `d_emb` in `N*EMB_DIM*N_LEN`: embedding vector.
- `valid_emb` in 1: `d_emb` strobe.
- `d_mix` in `HID_DIM*HID_DIM*N_LEN`: mix-layer result.
- `valid_mix` in 1: `d_mix` strobe.
- `q` out `HID_DIM*HID_DIM*N_LEN`: operand to the mix layer.
- `q_valid` out 1: operand valid.
- `q_ready` in 1: mix layer accepts the operand.
- `layer_idx` out `LW`: current layer.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at the end of a run.

## Operation
- Mode encodings:
  - EMB=0: `d_emb_buf` in the low `N*EMB_DIM` elements, upper elements zero.
  - PASS=1: `d_mix_buf` unchanged.
  - BCAST=2: element (i,j) = `d_mix_buf` element (i,0).
  - TRN=3: element (i,j) = `d_mix_buf` element (j,i).
- Element (i,j) sits at bit offset `(HID_DIM*i+j)*N_LEN`.
- FSM states and transitions:
  - IDLE→ISSUE on `start`.
  - ISSUE→WAIT on `q_valid & q_ready`.
  - WAIT→ISSUE on `valid_mix` when `layer_idx < N_LAYERS-1`; `layer_idx` increments.
  - WAIT→DONE on `valid_mix` at the last layer.
  - DONE→IDLE unconditionally.
- Buffer capture rules:
  - `d_emb_buf` captures on `valid_emb` in IDLE only; ignored otherwise.
  - `d_mix_buf` captures on `valid_mix` in WAIT only; ignored otherwise.
- `layer_mode` is latched on the accepted `start`. Later changes do not affect the run in progress.
- `layer_idx` resets to 0 on `start`.
- `q` source by state:
  - ISSUE: the latched mode of `layer_idx`.
  - All other states: `d_mix_buf`, so the final result stays readable after `done`.
- `q` is stable while `q_valid` is high.

## Timing
- Reset values: `q_valid`=0, `done`=0, `busy`=0, `layer_idx`=0, both buffers 0 (so `q`=0), state IDLE.
- `start` at edge t: `q_valid`=1 and `busy`=1 from t+1.
- `q_valid` holds until the edge where `q_ready`=1. It drops the following cycle.
- `valid_mix` at edge t in WAIT (not last layer): `d_mix_buf` is updated and `q_valid`=1 for the next layer from t+1.
- Last layer: `done`=1 for exactly the cycle after capture; `busy` falls the cycle after that.
- Minimum cost per layer: 1 ISSUE cycle plus the mix-layer latency.
- `start` together with `valid_emb` in IDLE: the new embedding is captured and used by layer 0.
- `start` while busy is ignored.
- `valid_mix` during ISSUE, DONE or IDLE is dropped.
- `rst_n` low mid-run: immediate return to reset values; no `done`.

## Configuration
- `MIX_SEQ_TRANSPOSE_EN` defined: mode 3 = TRN as above.
- `MIX_SEQ_TRANSPOSE_EN` undefined: the transpose network is not built and mode 3 behaves as PASS.

## Structure
- Shared package `mix_pkg` holds:
  - mode encodings (`MODE_EMB`, `MODE_PASS`, `MODE_BCAST`, `MODE_TRN`);
  - FSM state encodings;
  - the `N_LEN` element type.
- One sub-module, `mix_operand_mux`: purely combinational mode→operand formatting (pad, pass, broadcast, transpose), parametrised identically.
- The FSM, counter and buffers stay in the top module.

## Test plan
- **Basic run**: reset, `N_LAYERS`=3, modes {EMB, PASS, BCAST}, `d_emb` elements = index+1, mix model returns operand+1 per element after 4 cycles → layer-0 `q` equals the padded embedding with zeros above element `N*EMB_DIM-1`; the final `q` after `done` is correct; `done` is high for 1 cycle.
- **Backpressure**: hold `q_ready`=0 for 5 cycles in ISSUE → `q_valid` stays 1 and `q` is unchanged throughout; exactly one transfer occurs.
- **Broadcast and transpose**: load `d_mix` element (i,j)=16i+j, modes {PASS, BCAST, TRN} → BCAST `q`(i,j)=16i; TRN `q`(i,j)=16j+i. Without `MIX_SEQ_TRANSPOSE_EN`, TRN `q`(i,j)=16i+j.
- **Spurious strobes**: pulse `valid_mix` in IDLE and ISSUE, `valid_emb` during WAIT, and `start` while busy → buffers unchanged, `layer_idx` unchanged, no extra run.
- **Simultaneous and mode latch**: `start` and `valid_emb` on the same edge → layer 0 uses the new `d_emb`. Change `layer_mode` mid-run → the run still uses the latched modes.
- **Reset mid-run**: assert `rst_n`=0 in WAIT of layer 1 → all outputs 0 immediately and `done` never pulses. A new run after release completes normally.
